// File: rtl/pid_scheduler_if.sv
// Avalon-MM register port for pid_scheduler: word address, write/read strobes, 32-bit data.
// Latency: readdata is combinational from address; writes land on the next rising edge.
// Backpressure: none; the slave ties waitrequest low.
interface pid_scheduler_if;
    logic [3:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/pid_scheduler.sv
// Sequences one-hot measurement_update pulses over NUM_MOTORS PID channels once per PERIOD tick.
// Latency: tick to sweep_done = NUM_MOTORS*(1+SETTLE_CYCLES) cycles; register reads are combinational.
// Backpressure: none (waitrequest=0); ticks arriving mid-sweep are dropped, counted only with PID_SCHED_OVERRUN_CNT_EN.
// SETTLE_CYCLES is expected to be at least 1.
module pid_scheduler #(
    parameter int NUM_MOTORS    = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    pid_scheduler_if.slave          avs,
    output logic [NUM_MOTORS-1:0]   measurement_update,
    output logic [2*NUM_MOTORS-1:0] controller,
    output logic                    sweep_done
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TICK = 2'd1,
        S_ISSUE     = 2'd2,
        S_SETTLE    = 2'd3
    } state_t;

    localparam logic [3:0]  LAST_IDX    = 4'(NUM_MOTORS - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [31:0] PERIOD_RST  = 32'd50000;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_run;
    logic [31:0]             r_period;
    logic [31:0]             r_period_cur;
    logic [31:0]             r_tick_cnt;
    logic [NUM_MOTORS-1:0]   r_en_mask;
    logic [2*NUM_MOTORS-1:0] r_modes;
    logic [31:0]             r_sweep_cnt;
    logic [3:0]              r_index;
    logic [15:0]             r_settle_cnt;

    logic        w_wr_ctrl;
    logic        w_stop;
    logic        w_tick;
    logic        w_settle_last;
    logic        w_last_ch;
    logic [31:0] w_period_eff;
    logic [31:0] w_overrun_rd;
    logic        w_unused_read;

    assign w_wr_ctrl     = avs.write && (avs.address == 4'd0);
    // Clearing run takes the FSM to IDLE on the very next edge, not one cycle later.
    assign w_stop        = !r_run || (w_wr_ctrl && !avs.writedata[0]);
    assign w_period_eff  = (r_period < 32'd2) ? 32'd2 : r_period;
    assign w_tick        = r_run && (r_tick_cnt == r_period_cur - 32'd1);
    assign w_settle_last = (r_settle_cnt == SETTLE_LAST);
    assign w_last_ch     = (r_index == LAST_IDX);
    assign controller    = r_modes;
    assign avs.waitrequest = 1'b0;
    assign w_unused_read = avs.read;

    // Host-writable registers; RO and unmapped addresses fall through untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run     <= 1'b0;
            r_period  <= PERIOD_RST;
            r_en_mask <= '1;
            r_modes   <= '0;
        end else if (avs.write) begin
            case (avs.address)
                4'd0:    r_run     <= avs.writedata[0];
                4'd1:    r_period  <= avs.writedata;
                4'd2:    r_en_mask <= avs.writedata[NUM_MOTORS-1:0];
                4'd3:    r_modes   <= avs.writedata[2*NUM_MOTORS-1:0];
                default: ;
            endcase
        end
    end

    // Tick counter; the active period is only reloaded at a tick or while stopped so a running period is never cut short.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt   <= '0;
            r_period_cur <= PERIOD_RST;
        end else if (!r_run || w_tick) begin
            r_tick_cnt   <= '0;
            r_period_cur <= w_period_eff;
        end else begin
            r_tick_cnt   <= r_tick_cnt + 32'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next-state; a stop overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (r_run) w_state_nxt = S_WAIT_TICK;
            S_WAIT_TICK: if (w_tick) w_state_nxt = S_ISSUE;
            S_ISSUE:     w_state_nxt = S_SETTLE;
            S_SETTLE:    if (w_settle_last) w_state_nxt = w_last_ch ? S_WAIT_TICK : S_ISSUE;
            default:     w_state_nxt = S_IDLE;
        endcase
        if (w_stop) w_state_nxt = S_IDLE;
    end

    // FSM outputs: the update pulse is gated by the live enable mask so mid-sweep mask edits apply to later channels.
    always_comb begin
        measurement_update = '0;
        sweep_done         = 1'b0;
        if (r_state == S_ISSUE)
            measurement_update = r_en_mask & (NUM_MOTORS'(1) << r_index);
        if ((r_state == S_SETTLE) && w_settle_last && w_last_ch)
            sweep_done = 1'b1;
    end

    // Channel index, settle timer and sweep counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_index      <= '0;
            r_settle_cnt <= '0;
            r_sweep_cnt  <= '0;
        end else begin
            if (w_state_nxt == S_IDLE)
                r_index <= '0;
            else if ((r_state == S_WAIT_TICK) && (w_state_nxt == S_ISSUE))
                r_index <= '0;
            else if ((r_state == S_SETTLE) && (w_state_nxt == S_ISSUE))
                r_index <= r_index + 4'd1;

            if (r_state == S_ISSUE)
                r_settle_cnt <= '0;
            else if (r_state == S_SETTLE)
                r_settle_cnt <= r_settle_cnt + 16'd1;

            if (sweep_done)
                r_sweep_cnt <= r_sweep_cnt + 32'd1;
        end
    end

`ifdef PID_SCHED_OVERRUN_CNT_EN
    logic [31:0] r_overrun_cnt;
    logic        w_drop;

    assign w_drop       = w_tick && (r_state != S_WAIT_TICK);
    assign w_overrun_rd = r_overrun_cnt;

    // Count every tick that lands while a sweep (or startup) is still in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    r_overrun_cnt <= '0;
        else if (w_drop) r_overrun_cnt <= r_overrun_cnt + 32'd1;
    end
`else
    assign w_overrun_rd = '0;
`endif

    // Register readback, combinational from address.
    always_comb begin
        avs.readdata = 32'hDEAD_BEEF;
        case (avs.address)
            4'd0:    avs.readdata = {31'd0, r_run};
            4'd1:    avs.readdata = r_period;
            4'd2:    avs.readdata = 32'(r_en_mask);
            4'd3:    avs.readdata = 32'(r_modes);
            4'd4:    avs.readdata = r_sweep_cnt;
            4'd5:    avs.readdata = w_overrun_rd;
            4'd6:    avs.readdata = {24'd0, r_index, 2'b00, r_state};
            default: avs.readdata = 32'hDEAD_BEEF;
        endcase
    end
endmodule

// File: tb/tb_pid_scheduler.sv
// Scoreboard bench for pid_scheduler: expected pulses queued at stimulus time, matched at negedge.
// Latency: expected event cycles derived from run-write cycle, PERIOD and 3-cycle channel slots.
// Backpressure: none; waits are bounded by the bench cycle counter.
module tb_pid_scheduler;
    localparam int NM = 6;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [NM-1:0] mu;
        logic          sd;
    } ev_t;

    logic              clock;
    logic              reset_n;
    logic [NM-1:0]     measurement_update;
    logic [2*NM-1:0]   controller;
    logic              sweep_done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_sweeps = 0;
    ev_t  exp_q[$];
    ev_t  mon_got;
    ev_t  mon_want;

    pid_scheduler_if bus();

    pid_scheduler #(.NUM_MOTORS(NM), .SETTLE_CYCLES(2)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .avs                (bus),
        .measurement_update (measurement_update),
        .controller         (controller),
        .sweep_done         (sweep_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every pulse or sweep_done must match the head of the expected queue.
    always @(negedge clock) begin
        if (measurement_update != '0 || sweep_done) begin
            mon_got.cyc = 32'(cyc);
            mon_got.mu  = measurement_update;
            mon_got.sd  = sweep_done;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard unexpected cyc=%0d mu=%b sd=%b required no event", cyc, measurement_update, sweep_done);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    errors++;
                    $display("FAIL scoreboard got cyc=%0d mu=%b sd=%b required cyc=%0d mu=%b sd=%b",
                             mon_got.cyc, mon_got.mu, mon_got.sd, mon_want.cyc, mon_want.mu, mon_want.sd);
                end
            end
        end
    end

    function automatic void push_ev(int c, logic [NM-1:0] mu, logic sd);
        ev_t e;
        e.cyc = 32'(c);
        e.mu  = mu;
        e.sd  = sd;
        exp_q.push_back(e);
    endfunction

    // Tick seen at cycle t: channel k issues at t+1+3k, sweep_done at t+18.
    function automatic void push_sweep(int t, logic [NM-1:0] mask);
        for (int k = 0; k < NM; k++)
            if (mask[k]) push_ev(t + 1 + 3 * k, NM'(1) << k, 1'b0);
        push_ev(t + 3 * NM, '0, 1'b1);
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int s0);
        s0 = cyc;
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.write     = 1'b0;
        bus.address   = 4'd0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.address = a;
        bus.read    = 1'b1;
        #1;
        d = bus.readdata;
        bus.read    = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic test_reset;
        logic [3:0]  addrs [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd15};
        logic [31:0] exps  [8] = '{32'd0, 32'd50000, 32'h3F, 32'd0, 32'd0, 32'd0, 32'd0, 32'hDEAD_BEEF};
        logic [31:0] rd;
        checks++;
        if (measurement_update !== '0 || sweep_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs mu=%b sd=%b required 0 0", measurement_update, sweep_done);
        end
        checks++;
        if (controller !== '0 || bus.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl_wait controller=%h waitrequest=%b required 0 0", controller, bus.waitrequest);
        end
        reset_n = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            bus_read(addrs[i], rd);
            checks++;
            if (rd !== exps[i]) begin
                errors++;
                $display("FAIL reset_reg addr=%0d got %h required %h", addrs[i], rd, exps[i]);
            end
        end
    endtask

    task automatic test_sweep;
        int s0, t0;
        logic [31:0] rd;
        bus_write(4'd1, 32'd100, s0);
        bus_write(4'd0, 32'd1, s0);
        t0 = s0 + 100;
        push_sweep(t0, 6'h3F);
        push_sweep(t0 + 100, 6'h3F);
        push_sweep(t0 + 200, 6'h3F);
        exp_sweeps += 3;
        wait_until(t0 + 225);
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 32'(exp_sweeps)) begin errors++; $display("FAIL sweep_cnt got %0d required %0d", rd, exp_sweeps); end
        bus_read(4'd6, rd);
        checks++;
        if (rd !== 32'h51) begin errors++; $display("FAIL sweep_status got %h required 51", rd); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sweep_missing got %0d pending required 0", exp_q.size()); end
        bus_write(4'd0, 32'd0, s0);
    endtask

    task automatic test_en_mask;
        int s0, t0, t1, d;
        logic [31:0] rd;
        bus_write(4'd2, 32'h05, s0);
        bus_write(4'd0, 32'd1, s0);
        t0 = s0 + 100;
        t1 = t0 + 100;
        push_sweep(t0, 6'b000101);
        push_ev(t1 + 1, 6'b000001, 1'b0);
        push_ev(t1 + 7, 6'b000100, 1'b0);
        push_ev(t1 + 10, 6'b001000, 1'b0);
        push_ev(t1 + 13, 6'b010000, 1'b0);
        push_ev(t1 + 16, 6'b100000, 1'b0);
        push_ev(t1 + 18, 6'b000000, 1'b1);
        exp_sweeps += 2;
        wait_until(t1 + 5);
        bus_write(4'd2, 32'h3F, d);
        wait_until(t1 + 25);
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 32'(exp_sweeps)) begin errors++; $display("FAIL mask_sweep_cnt got %0d required %0d", rd, exp_sweeps); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mask_missing got %0d pending required 0", exp_q.size()); end
        bus_write(4'd0, 32'd0, s0);
    endtask

    task automatic test_modes_regs;
        int s0;
        logic [31:0] rd;
        bus_write(4'd3, 32'hFFFF_F924, s0);
        checks++;
        if (controller !== 12'h924) begin errors++; $display("FAIL modes_controller got %h required 924", controller); end
        bus_read(4'd3, rd);
        checks++;
        if (rd !== 32'h924) begin errors++; $display("FAIL modes_readback got %h required 924", rd); end
        bus_write(4'd4, 32'h1234, s0);
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 32'(exp_sweeps)) begin errors++; $display("FAIL ro_sweep_write got %h required %h", rd, exp_sweeps); end
        bus_write(4'd6, 32'hFF, s0);
        bus_read(4'd6, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL ro_status_write got %h required 0", rd); end
        bus_write(4'd12, 32'h1, s0);
        bus_read(4'd12, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unmapped_read got %h required deadbeef", rd); end
        bus_write(4'd0, 32'h2, s0);
        bus_read(4'd0, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL ctrl_bit0 got %h required 0", rd); end
        bus_read(4'd1, rd);
        checks++;
        if (rd !== 32'd100) begin errors++; $display("FAIL period_readback got %0d required 100", rd); end
    endtask

    task automatic test_overrun;
        int s0, t0;
        logic [31:0] rd;
        logic [31:0] exp_ovr;
        bus_write(4'd1, 32'd10, s0);
        bus_write(4'd0, 32'd1, s0);
        t0 = s0 + 10;
        push_sweep(t0, 6'h3F);
        push_sweep(t0 + 20, 6'h3F);
        push_sweep(t0 + 40, 6'h3F);
        exp_sweeps += 3;
        wait_until(t0 + 59);
        bus_write(4'd0, 32'd0, s0);
`ifdef PID_SCHED_OVERRUN_CNT_EN
        exp_ovr = 32'd3;
`else
        exp_ovr = 32'd0;
`endif
        bus_read(4'd5, rd);
        checks++;
        if (rd !== exp_ovr) begin errors++; $display("FAIL overrun_cnt got %0d required %0d", rd, exp_ovr); end
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 32'(exp_sweeps)) begin errors++; $display("FAIL overrun_sweep_cnt got %0d required %0d", rd, exp_sweeps); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL overrun_missing got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_stop;
        int s0, t0;
        logic [31:0] rd;
        bus_write(4'd1, 32'd100, s0);
        bus_write(4'd0, 32'd1, s0);
        t0 = s0 + 100;
        for (int k = 0; k < 4; k++) push_ev(t0 + 1 + 3 * k, NM'(1) << k, 1'b0);
        wait_until(t0 + 11);
        bus_read(4'd6, rd);
        checks++;
        if (rd !== 32'h33) begin errors++; $display("FAIL stop_status_settle got %h required 33", rd); end
        bus_write(4'd0, 32'd0, s0);
        bus_read(4'd6, rd);
        checks++;
        if (rd[1:0] !== 2'd0) begin errors++; $display("FAIL stop_state got %0d required 0", rd[1:0]); end
        bus_read(4'd15, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stop_addr15 got %h required deadbeef", rd); end
        wait_until(t0 + 60);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stop_missing got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        int s0, t0;
        logic [31:0] rd;
        logic [31:0] exp_ovr;
        logic [3:0]  addrs [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        logic [31:0] exps  [7] = '{32'd0, 32'd50000, 32'h3F, 32'd0, 32'd0, 32'd0, 32'd0};
        bus_write(4'd0, 32'd1, s0);
        t0 = s0 + 100;
        for (int k = 0; k < 3; k++) push_ev(t0 + 1 + 3 * k, NM'(1) << k, 1'b0);
        wait_until(t0 + 7);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (measurement_update !== '0 || sweep_done !== 1'b0 || controller !== '0) begin
            errors++;
            $display("FAIL async_reset mu=%b sd=%b controller=%h required 0 0 0", measurement_update, sweep_done, controller);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        exp_sweeps = 0;
        for (int i = 0; i < 7; i++) begin
            bus_read(addrs[i], rd);
            checks++;
            if (rd !== exps[i]) begin
                errors++;
                $display("FAIL rst_mid_reg addr=%0d got %h required %h", addrs[i], rd, exps[i]);
            end
        end
        wait_until(cyc + 150);
        bus_write(4'd1, 32'd1, s0);
        bus_write(4'd0, 32'd1, s0);
        t0 = s0 + 2;
        push_sweep(t0, 6'h3F);
        push_sweep(t0 + 20, 6'h3F);
        exp_sweeps += 2;
        wait_until(t0 + 39);
        bus_write(4'd0, 32'd0, s0);
`ifdef PID_SCHED_OVERRUN_CNT_EN
        exp_ovr = 32'd18;
`else
        exp_ovr = 32'd0;
`endif
        bus_read(4'd5, rd);
        checks++;
        if (rd !== exp_ovr) begin errors++; $display("FAIL period1_overrun got %0d required %0d", rd, exp_ovr); end
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 32'(exp_sweeps)) begin errors++; $display("FAIL period1_sweep_cnt got %0d required %0d", rd, exp_sweeps); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL period1_missing got %0d pending required 0", exp_q.size()); end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.address   = 4'd0;
        bus.write     = 1'b0;
        bus.writedata = 32'd0;
        bus.read      = 1'b0;
        repeat (3) @(negedge clock);
        test_reset;
        test_sweep;
        test_en_mask;
        test_modes_regs;
        test_overrun;
        test_stop;
        test_reset_mid;
        repeat (10) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
